riscv_fetch_buffer: RTL

- Instruction-fetch stage directly upstream of riscv_processor.
- Takes the processor's current PC and prefetches sequential instruction words from an instruction memory with a request/response handshake and variable latency.
- Holds prefetched words in a small in-order queue and presents the word matching the PC as Instruction.
- On a PC discontinuity (branch/jump), flushes the queue and squashes in-flight responses.

---
 rtl/riscv_fetch_buffer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_buffer.sv
// rtl/riscv_fetch_buffer.sv - sequential prefetch queue feeding the processor's instruction input (optional stats: FETCH_STATS_EN)
module riscv_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_ready,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] redirect_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    // Squashed responses can pile up across back-to-back redirects, so this
    // counter is wider than the credit counters.
    localparam int unsigned SW = 16;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   entries_q [DEPTH];
    logic [31:0]   entries_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [SW-1:0] squash_q, squash_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   head_pc_q, head_pc_d;

    logic [31:0] pc_aligned;
    logic        redirect;
    logic        accept;
    logic        push;
    logic        pop;
    logic        drop;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^cpu_pc[1:0];

    // Handshake and presentation signals derived from current state and inputs.
    always_comb begin
        pc_aligned  = {cpu_pc[31:2], 2'b00};
        // A PC that no longer matches the head means the processor took a branch.
        redirect    = (pc_aligned != head_pc_q);
        instr_valid = (count_q != '0) && !redirect;
        instr_out   = instr_valid ? entries_q[rd_ptr_q] : NOP_WORD;
        stall       = !instr_valid;
        // Credits cover both queued words and fetches still in flight.
        mem_req     = rst_n && !redirect &&
                      (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W);
        mem_addr    = fetch_addr_q;
        accept      = mem_req && mem_gnt;
        drop        = mem_rvalid && (squash_q != '0);
        push        = mem_rvalid && (squash_q == '0) && !redirect;
        pop         = instr_valid && cpu_ready;
    end

    // Next-state for queue, pointers, credits and squash bookkeeping.
    always_comb begin
        entries_d     = entries_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        squash_d      = squash_q;
        fetch_addr_d  = fetch_addr_q;
        head_pc_d     = head_pc_q;

        if (redirect) begin
            // Flush everything; whatever is still in flight becomes stale.
            // A response landing this cycle retires one of those stale words now.
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
            fetch_addr_d  = pc_aligned;
            head_pc_d     = pc_aligned;
            squash_d      = squash_q + SW'(outstanding_q) - SW'(mem_rvalid);
        end else begin
            if (accept) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (push) begin
                entries_d[wr_ptr_q] = mem_rdata;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                head_pc_d = head_pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            outstanding_d = outstanding_q + CW'(accept) - CW'(push);
            if (drop) begin
                squash_d = squash_q - 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            squash_q      <= '0;
            fetch_addr_q  <= RESET_PC;
            head_pc_q     <= RESET_PC;
        end else begin
            entries_q     <= entries_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            fetch_addr_q  <= fetch_addr_d;
            head_pc_q     <= head_pc_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] redirect_count_q, redirect_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Saturating event counters for redirects and stalled cycles.
    always_comb begin
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;
        if (redirect && (redirect_count_q != 32'hFFFF_FFFF)) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
    assign stall_count    = stall_count_q;
`endif

endmodule
